// File: rtl/keypad_num_entry.sv
// keypad_num_entry: multi-digit decimal entry from keypad key codes.
// Edits a BCD buffer with a cursor and shows it on active-low seven-segment
// patterns. ENTER converts the buffer to binary one digit per cycle and
// offers the result on a valid/ready handshake.
// Optional macro CURSOR_BLINK_EN: blinks the cursor digit's dp while idle.
module keypad_num_entry #(
  parameter int DIGITS    = 3,
  parameter int VAL_W     = 10,
  parameter int NEXT_CODE = 12,
  parameter int DEL_CODE  = 13,
  parameter int CLR_CODE  = 14,
  parameter int ENT_CODE  = 15,
  parameter int BLINK_DIV = 25_000_000,
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  key_vld,
  input  logic [3:0]            key_code,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [VAL_W-1:0]      value,
  output logic                  busy,
  output logic [CW-1:0]         cursor,
  output logic [8*DIGITS-1:0]   seg
);

  localparam int AW = VAL_W + 4;
  localparam logic [3:0] BLANK = 4'hF;
  localparam logic [CW-1:0] CUR_MAX = CW'(DIGITS - 1);
  localparam logic [CW-1:0] CUR_ONE = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t              state_reg, state_next;
  logic                key_vld_d_reg;
  logic [3:0]          slot_reg  [DIGITS];
  logic [3:0]          slot_next [DIGITS];
  logic [CW-1:0]       cursor_reg, cursor_next;
  logic [CW-1:0]       idx_reg;
  logic [AW-1:0]       acc_reg, acc_next;
  logic [VAL_W-1:0]    value_reg;
  logic                out_valid_reg;
  logic [8*DIGITS-1:0] seg_reg, seg_next;
  logic                evt_ok;
  logic                ent_evt;
  logic [3:0]          conv_digit;
  logic                cur_lit;

  // Segment pattern for one slot; bit 7 (dp) is replaced by the caller.
  function automatic logic [7:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0: seg_pat = 8'hC0;
      4'd1: seg_pat = 8'hF9;
      4'd2: seg_pat = 8'hA4;
      4'd3: seg_pat = 8'hB0;
      4'd4: seg_pat = 8'h99;
      4'd5: seg_pat = 8'h92;
      4'd6: seg_pat = 8'h82;
      4'd7: seg_pat = 8'hF8;
      4'd8: seg_pat = 8'h80;
      4'd9: seg_pat = 8'h90;
      default: seg_pat = 8'hF7;
    endcase
  endfunction

  // A key press counts once, on its rising edge, and only while idle and enabled.
  assign evt_ok  = key_vld & ~key_vld_d_reg & en & (state_reg == S_IDLE);
  assign ent_evt = evt_ok & (key_code == 4'(ENT_CODE));

  // Key-press edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_vld_d_reg <= 1'b0;
    else     key_vld_d_reg <= key_vld;
  end

  // Buffer/cursor editing for digit, NEXT, DEL and CLR keys.
  always_comb begin
    slot_next   = slot_reg;
    cursor_next = cursor_reg;
    if (evt_ok) begin
      if (key_code <= 4'd9) begin
        slot_next[cursor_reg] = key_code;
        if (cursor_reg != CUR_MAX) cursor_next = cursor_reg + CUR_ONE;
      end else if (key_code == 4'(NEXT_CODE)) begin
        cursor_next = (cursor_reg == CUR_MAX) ? '0 : cursor_reg + CUR_ONE;
      end else if (key_code == 4'(DEL_CODE)) begin
        if (slot_reg[cursor_reg] == BLANK && cursor_reg != '0) begin
          cursor_next = cursor_reg - CUR_ONE;
          slot_next[cursor_reg - CUR_ONE] = BLANK;
        end else begin
          slot_next[cursor_reg] = BLANK;
        end
      end else if (key_code == 4'(CLR_CODE)) begin
        for (int i = 0; i < DIGITS; i++) slot_next[i] = BLANK;
        cursor_next = '0;
      end
    end
  end

  // Buffer and cursor registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) slot_reg[i] <= BLANK;
      cursor_reg <= '0;
    end else begin
      slot_reg   <= slot_next;
      cursor_reg <= cursor_next;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // FSM next-state: ENTER starts conversion, last digit finishes it, ready releases it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (ent_evt) state_next = S_CONV;
      S_CONV: if (idx_reg == CUR_MAX) state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Multiply-accumulate step; blank slots contribute zero.
  assign conv_digit = (slot_reg[idx_reg] == BLANK) ? 4'd0 : slot_reg[idx_reg];
  assign acc_next   = acc_reg * AW'(10) + AW'(conv_digit);

  // Conversion datapath and output handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg       <= '0;
      idx_reg       <= '0;
      value_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: if (ent_evt) begin
          acc_reg <= '0;
          idx_reg <= '0;
        end
        S_CONV: begin
          acc_reg <= acc_next;
          idx_reg <= idx_reg + CUR_ONE;
          if (idx_reg == CUR_MAX) begin
            value_reg     <= acc_next[VAL_W-1:0];
            out_valid_reg <= 1'b1;
          end
        end
        S_DONE: if (out_ready) out_valid_reg <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);
  logic [BW-1:0] blink_cnt_reg;
  logic          blink_phase_reg;

  // Blink timebase: phase flips every BLINK_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (blink_cnt_reg == BW'(BLINK_DIV - 1)) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= ~blink_phase_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BW'(1);
    end
  end

  assign cur_lit = blink_phase_reg & en & (state_reg == S_IDLE);
`else
  assign cur_lit = 1'b0;
`endif

  // Per-digit display pattern; digit 0 lands in the most significant byte.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
    logic [7:0] pat;
    assign pat = seg_pat(slot_reg[gi]);
    assign seg_next[8*(DIGITS-1-gi) +: 8] = {~(cur_lit && (cursor_reg == CW'(gi))), pat[6:0]};
  end

  // Display register, one cycle behind the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) seg_reg <= {DIGITS{8'hF7}};
    else     seg_reg <= seg_next;
  end

  assign out_valid = out_valid_reg;
  assign value     = value_reg;
  assign busy      = (state_reg != S_IDLE);
  assign cursor    = cursor_reg;
  assign seg       = seg_reg;

endmodule

// File: tb/tb_keypad_num_entry.sv
// Directed bench for keypad_num_entry: a 3-digit instance for editing,
// handshake and reset behaviour, and a 4-digit instance for wide results.
// Expected committed values go into a queue when ENTER is pressed and are
// popped when out_valid is seen.
module tb_keypad_num_entry;

  logic clk = 1'b0;
  logic rst, en, key_vld, out_ready, sel;
  logic [3:0] key_code;

  logic        ov3, busy3;
  logic [9:0]  val3;
  logic [1:0]  cur3;
  logic [23:0] seg3;

  logic        ov4, busy4;
  logic [13:0] val4;
  logic [1:0]  cur4;
  logic [31:0] seg4;

  logic kv3, kv4;
  assign kv3 = key_vld & ~sel;
  assign kv4 = key_vld & sel;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  keypad_num_entry #(.DIGITS(3), .VAL_W(10)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .key_vld(kv3), .key_code(key_code),
    .out_ready(out_ready), .out_valid(ov3), .value(val3), .busy(busy3),
    .cursor(cur3), .seg(seg3)
  );

  keypad_num_entry #(.DIGITS(4), .VAL_W(14)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .key_vld(kv4), .key_code(key_code),
    .out_ready(out_ready), .out_valid(ov4), .value(val4), .busy(busy4),
    .cursor(cur4), .seg(seg4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-12s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    key_code = code;
    key_vld  = 1'b1;
    step();
    key_vld  = 1'b0;
    step();
  endtask

  task automatic ent(input logic [63:0] expv);
    exp_q.push_back(expv);
    key_code = 4'd15;
    key_vld  = 1'b1;
    step();
    key_vld  = 1'b0;
    chk("busy_conv", sel ? busy4 : busy3, 1'b1);
  endtask

  // Counts edges from the ENT edge until out_valid, then checks the value.
  task automatic wait_valid(input int exp_edges);
    int n = 0;
    while (!(sel ? ov4 : ov3) && n < 40) begin
      step();
      n++;
    end
    chk("latency", 64'(n), 64'(exp_edges));
    chk("out_valid", sel ? ov4 : ov3, 1'b1);
    if (exp_q.size() > 0) chk("value", sel ? 64'(val4) : 64'(val3), exp_q.pop_front());
    else chk("sb_empty", 64'(exp_q.size()), 64'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; key_vld = 1'b0; key_code = 4'd0; out_ready = 1'b0; sel = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_seg", seg3, 24'hF7F7F7);
    chk("rst_cursor", cur3, 2'd0);
    chk("rst_value", val3, 10'd0);
    chk("rst_valid", ov3, 1'b0);
    chk("rst_busy", busy3, 1'b0);

    // 1,2,3 then ENTER
    press(4'd1); chk("cur_a", cur3, 2'd1);
    press(4'd2); chk("cur_b", cur3, 2'd2);
    press(4'd3); chk("cur_sat", cur3, 2'd2);
    chk("seg_123", seg3, 24'hF9A4B0);
    out_ready = 1'b1;
    ent(123);
    wait_valid(3);
    chk("busy_done", busy3, 1'b1);
    step();
    chk("valid_drop", ov3, 1'b0);
    chk("busy_idle", busy3, 1'b0);

    // DEL on a filled slot, then DEL on a blank slot
    press(4'd4); chk("seg_124", seg3, 24'hF9A499);
    press(4'd13); chk("del_fill", seg3, 24'hF9A4F7); chk("del_fcur", cur3, 2'd2);
    press(4'd13); chk("del_back", seg3, 24'hF9F7F7); chk("del_bcur", cur3, 2'd1);

    // CLR, 4, DEL, DEL, 7 -> 700
    press(4'd14); chk("clr_seg", seg3, 24'hF7F7F7); chk("clr_cur", cur3, 2'd0);
    press(4'd4); press(4'd13); press(4'd13);
    chk("deldel_cur", cur3, 2'd0);
    chk("deldel_seg", seg3, 24'hF7F7F7);
    press(4'd7); chk("seg_7", seg3, 24'hF8F7F7);
    ent(700);
    wait_valid(3);
    step();

    // NEXT wrap and ignored code
    press(4'd14);
    press(4'd5);  chk("nx_c0", cur3, 2'd1);
    press(4'd12); chk("nx_c1", cur3, 2'd2);
    press(4'd12); chk("nx_c2", cur3, 2'd0);
    press(4'd12); chk("nx_c3", cur3, 2'd1);
    chk("nx_seg", seg3, 24'h92F7F7);
    press(4'd10); chk("ign_seg", seg3, 24'h92F7F7); chk("ign_cur", cur3, 2'd1);

    // Hold off ready in DONE while pressing keys
    out_ready = 1'b0;
    ent(500);
    wait_valid(3);
    for (int i = 0; i < 5; i++) begin
      press((i % 2 == 0) ? 4'd9 : 4'd14);
      chk("hold_valid", ov3, 1'b1);
      chk("hold_value", val3, 10'd500);
      chk("hold_seg", seg3, 24'h92F7F7);
      chk("hold_cur", cur3, 2'd1);
    end
    out_ready = 1'b1;
    step();
    chk("rel_valid", ov3, 1'b0);

    // Entry disabled
    en = 1'b0;
    press(4'd8);
    chk("en0_seg", seg3, 24'h92F7F7);
    chk("en0_cur", cur3, 2'd1);
    en = 1'b1;

    // Reset mid-conversion
    ent(500);
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_busy", busy3, 1'b0);
    chk("mid_valid", ov3, 1'b0);
    chk("mid_value", val3, 10'd0);
    chk("mid_seg", seg3, 24'hF7F7F7);
    chk("mid_cur", cur3, 2'd0);
    step();
    rst = 1'b0;
    step();
    ent(0);
    wait_valid(3);
    step();

    // 4-digit instance: 9999
    sel = 1'b1;
    press(4'd9); press(4'd9); press(4'd9); press(4'd9);
    chk("d4_cur", cur4, 2'd3);
    chk("d4_seg", seg4, 32'h90909090);
    ent(9999);
    wait_valid(4);
    step();
    chk("d4_drop", ov4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
